// File: rtl/instr_fetch_sequencer.sv
// Program sequencer for a 1-cycle registered instruction RAM: owns the PC, issues
// instructions to the control unit, resolves conditional jumps locally and halts on NOP.
module instr_fetch_sequencer #(
  parameter int ADDR_W     = 9,
  parameter int INSTR_W    = 16,
  parameter int OP_W       = 6,
  parameter int START_ADDR = 0,
  parameter int PROG_DEPTH = 201,
  parameter int OP_NOP     = 46,
  parameter int OP_JUMPNZ  = 47,
  parameter int OP_JUMPZ   = 52
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [ADDR_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]      imem_data,
  output logic [INSTR_W-1:0]      ir,
  output logic [OP_W-1:0]         opcode,
  output logic [INSTR_W-OP_W-1:0] imm,
  output logic                    ir_valid,
  input  logic                    exec_done,
  input  logic                    z_flag,
  output logic [ADDR_W-1:0]       pc,
  output logic                    busy,
  output logic                    halted,
  output logic                    err,
  output logic [15:0]             instr_count
);

  localparam int IMM_W = INSTR_W - OP_W;
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W+1)'(PROG_DEPTH);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(START_ADDR);
  localparam logic [OP_W-1:0]   NOP_OP    = OP_W'(OP_NOP);
  localparam logic [OP_W-1:0]   JNZ_OP    = OP_W'(OP_JUMPNZ);
  localparam logic [OP_W-1:0]   JZ_OP     = OP_W'(OP_JUMPZ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic [INSTR_W-1:0]  ir_next;
  logic                ir_valid_next;
  logic                err_next;
  logic [15:0]         count_next;

  logic [OP_W-1:0]     load_op;
  logic [ADDR_W-1:0]   jump_target;
  logic [ADDR_W-1:0]   pc_inc;
  logic                is_jump;
  logic                jump_taken;
  logic                target_bad;
  logic                inc_bad;
  logic                pc_bad;
  logic [15:0]         count_inc;

  assign load_op     = imem_data[INSTR_W-1:IMM_W];
  assign jump_target = imem_data[ADDR_W-1:0];
  assign pc_inc      = pc + ADDR_W'(1);
  assign is_jump     = (load_op == JZ_OP) || (load_op == JNZ_OP);
  assign jump_taken  = (load_op == JZ_OP) ? z_flag : ~z_flag;
  assign target_bad  = {1'b0, jump_target} >= DEPTH_LIM;
  assign inc_bad     = {1'b0, pc_inc} >= DEPTH_LIM;
  assign pc_bad      = {1'b0, pc} >= DEPTH_LIM;
  assign count_inc   = (instr_count == 16'hFFFF) ? instr_count : instr_count + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // In EXEC, a high ir_valid marks the first cycle, during which exec_done is ignored.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_next       = ir;
    ir_valid_next = 1'b0;
    err_next      = err;
    count_next    = instr_count;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_next = S_FETCH;
          pc_next    = START_PC;
          err_next   = 1'b0;
          count_next = 16'd0;
        end
      end
      S_FETCH: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        if (is_jump) begin
          if (jump_taken) begin
            if (target_bad) begin
              err_next   = 1'b1;
              state_next = S_HALT;
            end else begin
              pc_next    = jump_target;
              state_next = S_FETCH;
            end
          end else begin
            pc_next = pc_inc;
            if (inc_bad) begin
              err_next   = 1'b1;
              state_next = S_HALT;
            end else begin
              state_next = S_FETCH;
            end
          end
        end else if (load_op == NOP_OP) begin
          state_next = S_HALT;
        end else begin
          ir_next       = imem_data;
          pc_next       = pc_inc;
          ir_valid_next = 1'b1;
          count_next    = count_inc;
          state_next    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!ir_valid && exec_done) begin
          if (pc_bad) begin
            err_next   = 1'b1;
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= START_PC;
      ir          <= '0;
      ir_valid    <= 1'b0;
      err         <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      pc          <= pc_next;
      ir          <= ir_next;
      ir_valid    <= ir_valid_next;
      err         <= err_next;
      instr_count <= count_next;
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir[INSTR_W-1:IMM_W];
  assign imm       = ir[IMM_W-1:0];
  assign busy      = (state == S_FETCH) || (state == S_LOAD) || (state == S_EXEC);
  assign halted    = (state == S_HALT);

endmodule
